// File: rtl/jtroadf_arb_pkg.sv
// Shared definitions for the Road Fighter SDRAM read arbiter: slot indices,
// FSM state encoding and the fixed grant priority order.
package jtroadf_arb_pkg;

  localparam int unsigned NSLOT = 5;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_SCR  = 3'd0;
  localparam slot_t SLOT_OBJ  = 3'd1;
  localparam slot_t SLOT_PCM  = 3'd2;
  localparam slot_t SLOT_SND  = 3'd3;
  localparam slot_t SLOT_MAIN = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } arb_state_t;

  // Highest priority first
  localparam slot_t PRIO [NSLOT] = '{SLOT_MAIN, SLOT_SND, SLOT_OBJ, SLOT_PCM, SLOT_SCR};

endpackage

// File: rtl/jtroadf_arb_slot.sv
// One-entry read cache for a single ROM consumer: hit compare, byte select
// and SDRAM word-address generation.
module jtroadf_arb_slot #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8,
  parameter logic [21:0] OFFSET = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          grant,
  input  logic          busy,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic          fill,
  input  logic [15:0]   din,
  output logic [DW-1:0] dout,
  output logic          ok,
  output logic          pending,
  output logic [21:0]   word_addr
);

  // Byte-wide slots share one 16-bit word between two byte addresses
  localparam logic [AW-1:0] CMP_MASK = (DW == 32) ? {AW{1'b1}} : {{(AW-1){1'b1}}, 1'b0};

  logic          valid;
  logic [AW-1:0] tag;
  logic [AW-1:0] pend_tag;
  logic [15:0]   data_lo;
  logic [21:0]   raw_addr;
  logic          match;

  assign match    = ((addr ^ tag) & CMP_MASK) == '0;
  assign ok       = cs & valid & match & ~downloading;
  assign pending  = cs & ~ok & ~busy;
  assign raw_addr = OFFSET + 22'(addr[AW-1:1]);
  assign word_addr = (DW == 32) ? (raw_addr & ~22'd1) : raw_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid    <= 1'b0;
      tag      <= '0;
      pend_tag <= '0;
      data_lo  <= '0;
    end else begin
      if (grant) pend_tag <= addr;
      if (wr_lo) data_lo  <= din;
      if (fill) begin
        tag   <= pend_tag;
        valid <= 1'b1;
      end
      if (downloading) valid <= 1'b0;
    end
  end

  if (DW == 32) begin : g_wide
    logic [15:0] data_hi;
    always_ff @(posedge clk) begin
      if (!rst)       data_hi <= '0;
      else if (wr_hi) data_hi <= din;
    end
    assign dout = {data_hi, data_lo};
  end else begin : g_byte
    logic unused_hi;
    assign unused_hi = wr_hi;
    assign dout = addr[0] ? data_lo[15:8] : data_lo[7:0];
  end

endmodule

// File: rtl/jtroadf_sdram_arb.sv
// Fixed-priority arbiter sharing the SDRAM read port among the five Road
// Fighter ROM consumers, each fronted by a one-entry cache.
module jtroadf_sdram_arb
  import jtroadf_arb_pkg::*;
#(
  parameter logic [21:0] SCR_OFFSET  = 22'h0,
  parameter logic [21:0] OBJ_OFFSET  = 22'h0,
  parameter logic [21:0] PCM_OFFSET  = 22'h0,
  parameter logic [21:0] SND_OFFSET  = 22'h0,
  parameter logic [21:0] MAIN_OFFSET = 22'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        scr_cs,
  input  logic        obj_cs,
  input  logic        pcm_cs,
  input  logic        snd_cs,
  input  logic        main_cs,
  input  logic [14:0] scr_addr,
  input  logic [14:0] obj_addr,
  input  logic [15:0] pcm_addr,
  input  logic [12:0] snd_addr,
  input  logic [15:0] main_addr,
  output logic [31:0] scr_dout,
  output logic [31:0] obj_dout,
  output logic [7:0]  pcm_dout,
  output logic [7:0]  snd_dout,
  output logic [7:0]  main_dout,
  output logic        scr_ok,
  output logic        obj_ok,
  output logic        pcm_ok,
  output logic        snd_ok,
  output logic        main_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_dst,
  input  logic        data_rdy,
  input  logic [15:0] data_read
);

  arb_state_t       state, state_nxt;
  slot_t            sel, pick;
  logic             second, start, wr_lo, wr_hi, fill;
  logic [NSLOT-1:0] pending, grant, busy, slot_lo, slot_hi, slot_fill;
  logic [21:0]      word_addr [NSLOT];

  // Lowest priority first so the highest pending slot wins the last write
  always_comb begin
    pick = SLOT_SCR;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (pending[PRIO[NSLOT-1-k]]) pick = PRIO[NSLOT-1-k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!downloading && (|pending)) state_nxt = ST_REQ;
      ST_REQ:  if (sdram_ack) state_nxt = ST_WAIT;
      ST_WAIT: if (data_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sdram_req = state == ST_REQ;
    start     = (state == ST_IDLE) && !downloading && (|pending);
    wr_lo     = (state == ST_WAIT) && data_dst && !second;
    wr_hi     = (state == ST_WAIT) && data_dst && second;
    fill      = (state == ST_WAIT) && data_rdy;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel        <= SLOT_SCR;
      sdram_addr <= '0;
      second     <= 1'b0;
    end else begin
      if (start) begin
        sel        <= pick;
        sdram_addr <= word_addr[pick];
        second     <= 1'b0;
      end
      if (wr_lo) second <= 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NSLOT; i++) begin
      grant[i]     = start && (pick == slot_t'(i));
      busy[i]      = (state != ST_IDLE) && (sel == slot_t'(i));
      slot_lo[i]   = wr_lo && (sel == slot_t'(i));
      slot_hi[i]   = wr_hi && (sel == slot_t'(i));
      slot_fill[i] = fill && (sel == slot_t'(i));
    end
  end

  jtroadf_arb_slot #(.AW(15), .DW(32), .OFFSET(SCR_OFFSET)) u_scr (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(scr_cs), .addr(scr_addr),
    .grant(grant[SLOT_SCR]), .busy(busy[SLOT_SCR]), .wr_lo(slot_lo[SLOT_SCR]),
    .wr_hi(slot_hi[SLOT_SCR]), .fill(slot_fill[SLOT_SCR]), .din(data_read),
    .dout(scr_dout), .ok(scr_ok), .pending(pending[SLOT_SCR]), .word_addr(word_addr[SLOT_SCR])
  );

  jtroadf_arb_slot #(.AW(15), .DW(32), .OFFSET(OBJ_OFFSET)) u_obj (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(obj_cs), .addr(obj_addr),
    .grant(grant[SLOT_OBJ]), .busy(busy[SLOT_OBJ]), .wr_lo(slot_lo[SLOT_OBJ]),
    .wr_hi(slot_hi[SLOT_OBJ]), .fill(slot_fill[SLOT_OBJ]), .din(data_read),
    .dout(obj_dout), .ok(obj_ok), .pending(pending[SLOT_OBJ]), .word_addr(word_addr[SLOT_OBJ])
  );

  jtroadf_arb_slot #(.AW(16), .DW(8), .OFFSET(PCM_OFFSET)) u_pcm (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(pcm_cs), .addr(pcm_addr),
    .grant(grant[SLOT_PCM]), .busy(busy[SLOT_PCM]), .wr_lo(slot_lo[SLOT_PCM]),
    .wr_hi(slot_hi[SLOT_PCM]), .fill(slot_fill[SLOT_PCM]), .din(data_read),
    .dout(pcm_dout), .ok(pcm_ok), .pending(pending[SLOT_PCM]), .word_addr(word_addr[SLOT_PCM])
  );

  jtroadf_arb_slot #(.AW(13), .DW(8), .OFFSET(SND_OFFSET)) u_snd (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(snd_cs), .addr(snd_addr),
    .grant(grant[SLOT_SND]), .busy(busy[SLOT_SND]), .wr_lo(slot_lo[SLOT_SND]),
    .wr_hi(slot_hi[SLOT_SND]), .fill(slot_fill[SLOT_SND]), .din(data_read),
    .dout(snd_dout), .ok(snd_ok), .pending(pending[SLOT_SND]), .word_addr(word_addr[SLOT_SND])
  );

  jtroadf_arb_slot #(.AW(16), .DW(8), .OFFSET(MAIN_OFFSET)) u_main (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(main_cs), .addr(main_addr),
    .grant(grant[SLOT_MAIN]), .busy(busy[SLOT_MAIN]), .wr_lo(slot_lo[SLOT_MAIN]),
    .wr_hi(slot_hi[SLOT_MAIN]), .fill(slot_fill[SLOT_MAIN]), .din(data_read),
    .dout(main_dout), .ok(main_ok), .pending(pending[SLOT_MAIN]), .word_addr(word_addr[SLOT_MAIN])
  );

endmodule

// File: tb/tb_jtroadf_sdram_arb.sv
// Directed bench for jtroadf_sdram_arb: fills, priority, hit compare,
// in-flight address change, reset and download blocking.
module tb_jtroadf_sdram_arb;

  logic        clk = 1'b0;
  logic        rst, downloading;
  logic        scr_cs, obj_cs, pcm_cs, snd_cs, main_cs;
  logic [14:0] scr_addr, obj_addr;
  logic [15:0] pcm_addr, main_addr;
  logic [12:0] snd_addr;
  logic [31:0] scr_dout, obj_dout;
  logic [7:0]  pcm_dout, snd_dout, main_dout;
  logic        scr_ok, obj_ok, pcm_ok, snd_ok, main_ok;
  logic        sdram_req, sdram_ack, data_dst, data_rdy;
  logic [21:0] sdram_addr;
  logic [15:0] data_read;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  jtroadf_sdram_arb #(
    .SCR_OFFSET(22'h8000), .OBJ_OFFSET(22'h4000), .PCM_OFFSET(22'h2000),
    .SND_OFFSET(22'h1000), .MAIN_OFFSET(22'h0)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .scr_cs(scr_cs), .obj_cs(obj_cs), .pcm_cs(pcm_cs), .snd_cs(snd_cs), .main_cs(main_cs),
    .scr_addr(scr_addr), .obj_addr(obj_addr), .pcm_addr(pcm_addr),
    .snd_addr(snd_addr), .main_addr(main_addr),
    .scr_dout(scr_dout), .obj_dout(obj_dout), .pcm_dout(pcm_dout),
    .snd_dout(snd_dout), .main_dout(main_dout),
    .scr_ok(scr_ok), .obj_ok(obj_ok), .pcm_ok(pcm_ok), .snd_ok(snd_ok), .main_ok(main_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [21:0] exp_addr, output int waited);
    waited = 0;
    while (!sdram_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_req"}, 32'(sdram_req), 32'd1);
    check({tag, "_addr"}, 32'(sdram_addr), 32'(exp_addr));
  endtask

  // Ack on the first REQ cycle, then two back-to-back data words
  task automatic burst(input logic [15:0] w0, input logic [15:0] w1);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    data_dst  = 1'b1;
    data_read = w0;
    @(negedge clk);
    data_rdy  = 1'b1;
    data_read = w1;
    @(negedge clk);
    data_dst  = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
  endtask

  initial begin
    rst = 1'b0; downloading = 1'b0;
    scr_cs = 0; obj_cs = 0; pcm_cs = 0; snd_cs = 0; main_cs = 0;
    scr_addr = '0; obj_addr = '0; pcm_addr = '0; snd_addr = '0; main_addr = '0;
    sdram_ack = 0; data_dst = 0; data_rdy = 0; data_read = '0;
    repeat (3) @(negedge clk);

    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_ok", 32'({scr_ok, obj_ok, pcm_ok, snd_ok, main_ok}), 32'd0);
    check("rst_scr_dout", scr_dout, 32'd0);
    check("rst_main_dout", 32'(main_dout), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single main request with REQ held for one extra cycle before ack
    main_cs = 1'b1; main_addr = 16'h0123;
    wait_req("main1", 22'h0091, lat);
    check("main1_lat", 32'(lat), 32'd1);
    @(negedge clk);
    check("main1_hold_req", 32'(sdram_req), 32'd1);
    check("main1_hold_addr", 32'(sdram_addr), 32'h91);
    check("main1_ok_before", 32'(main_ok), 32'd0);
    burst(16'hBEEF, 16'h0000);
    check("main1_ok", 32'(main_ok), 32'd1);
    check("main1_dout", 32'(main_dout), 32'hBE);
    main_cs = 1'b0;
    #1 check("main1_cs_drop", 32'(main_ok), 32'd0);
    @(negedge clk);

    // 32-bit assembly, then odd word index forced even
    scr_cs = 1'b1; scr_addr = 15'h0004;
    wait_req("scr1", 22'h8002, lat);
    burst(16'h3344, 16'h1122);
    check("scr1_ok", 32'(scr_ok), 32'd1);
    check("scr1_dout", scr_dout, 32'h11223344);
    scr_addr = 15'h0006;
    #1 check("scr2_miss", 32'(scr_ok), 32'd0);
    wait_req("scr2", 22'h8002, lat);
    check("scr2_lat", 32'(lat), 32'd1);
    burst(16'h5566, 16'h7788);
    check("scr2_dout", scr_dout, 32'h77885566);
    scr_cs = 1'b0;
    @(negedge clk);

    // Priority: MAIN, SND, OBJ, SCR
    scr_cs = 1; obj_cs = 1; snd_cs = 1; main_cs = 1;
    scr_addr = 15'h0010; obj_addr = 15'h0100; snd_addr = 13'h0040; main_addr = 16'h0200;
    wait_req("pri_main", 22'h0100, lat);
    check("pri_main_lat", 32'(lat), 32'd1);
    burst(16'h00AA, 16'h0000);
    wait_req("pri_snd", 22'h1020, lat);
    check("pri_snd_lat", 32'(lat), 32'd1);
    burst(16'hC3D4, 16'h0000);
    wait_req("pri_obj", 22'h4080, lat);
    check("pri_obj_lat", 32'(lat), 32'd1);
    burst(16'h5678, 16'h1234);
    wait_req("pri_scr", 22'h8008, lat);
    check("pri_scr_lat", 32'(lat), 32'd1);
    burst(16'hCDEF, 16'h89AB);
    check("pri_ok", 32'({scr_ok, obj_ok, snd_ok, main_ok}), 32'hF);
    check("pri_main_dout", 32'(main_dout), 32'hAA);
    check("pri_snd_dout", 32'(snd_dout), 32'hD4);
    check("pri_obj_dout", obj_dout, 32'h12345678);
    check("pri_scr_dout", scr_dout, 32'h89ABCDEF);
    @(negedge clk);
    check("pri_idle", 32'(sdram_req), 32'd0);
    scr_cs = 0; obj_cs = 0; snd_cs = 0; main_cs = 0;
    @(negedge clk);

    // Byte hit and word mismatch on PCM
    pcm_cs = 1'b1; pcm_addr = 16'h0010;
    wait_req("pcm1", 22'h2008, lat);
    burst(16'hA55A, 16'hFFFF);
    check("pcm1_ok", 32'(pcm_ok), 32'd1);
    check("pcm1_dout", 32'(pcm_dout), 32'h5A);
    pcm_addr = 16'h0011;
    #1 check("pcm_hi_ok", 32'(pcm_ok), 32'd1);
    check("pcm_hi_dout", 32'(pcm_dout), 32'hA5);
    @(negedge clk);
    check("pcm_hi_noreq", 32'(sdram_req), 32'd0);
    pcm_addr = 16'h0012;
    #1 check("pcm_miss_ok", 32'(pcm_ok), 32'd0);
    wait_req("pcm2", 22'h2009, lat);
    check("pcm2_lat", 32'(lat), 32'd1);
    burst(16'h1357, 16'h0000);
    check("pcm2_dout", 32'(pcm_dout), 32'h57);
    pcm_cs = 1'b0;
    @(negedge clk);

    // Address change while the burst is in flight
    snd_cs = 1'b1; snd_addr = 13'h0100;
    wait_req("snd1", 22'h1080, lat);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; snd_addr = 13'h0102;
    data_dst = 1'b1; data_read = 16'h1111;
    @(negedge clk);
    data_rdy = 1'b1; data_read = 16'h2222;
    @(negedge clk);
    data_dst = 1'b0; data_rdy = 1'b0;
    check("snd_inflight_ok", 32'(snd_ok), 32'd0);
    wait_req("snd2", 22'h1081, lat);
    check("snd2_lat", 32'(lat), 32'd1);
    burst(16'h6655, 16'h0000);
    check("snd2_ok", 32'(snd_ok), 32'd1);
    check("snd2_dout", 32'(snd_dout), 32'h55);
    snd_cs = 1'b0;
    @(negedge clk);

    // Reset during WAIT, then a stray data_rdy
    main_cs = 1'b1; main_addr = 16'h0300;
    wait_req("mrst", 22'h0180, lat);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; data_dst = 1'b1; data_read = 16'h1111;
    @(negedge clk);
    rst = 1'b0; main_cs = 1'b0; data_dst = 1'b0;
    @(negedge clk);
    check("mrst_req", 32'(sdram_req), 32'd0);
    check("mrst_dout", 32'(main_dout), 32'd0);
    rst = 1'b1; data_dst = 1'b1; data_rdy = 1'b1; data_read = 16'hFFFF;
    @(negedge clk);
    data_dst = 1'b0; data_rdy = 1'b0;
    check("stray_req", 32'(sdram_req), 32'd0);
    check("stray_dout", 32'(main_dout), 32'd0);
    main_cs = 1'b1;
    #1 check("stray_ok", 32'(main_ok), 32'd0);
    wait_req("mrst2", 22'h0180, lat);
    check("mrst2_lat", 32'(lat), 32'd1);
    burst(16'h4321, 16'h0000);
    check("mrst2_ok", 32'(main_ok), 32'd1);
    check("mrst2_dout", 32'(main_dout), 32'h21);

    // Download blocks grants and hides every cached entry
    downloading = 1'b1;
    scr_cs = 1; obj_cs = 1; pcm_cs = 1; snd_cs = 1;
    #1 check("dl_ok", 32'({scr_ok, obj_ok, pcm_ok, snd_ok, main_ok}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dl_noreq", 32'(sdram_req), 32'd0);
    end
    scr_cs = 0; obj_cs = 0; pcm_cs = 0; snd_cs = 0;
    downloading = 1'b0;
    #1 check("dl_valid_cleared", 32'(main_ok), 32'd0);
    wait_req("dl1", 22'h0180, lat);
    check("dl1_lat", 32'(lat), 32'd1);
    burst(16'h4321, 16'h0000);
    check("dl1_ok", 32'(main_ok), 32'd1);

    // Download raised mid-burst discards the fill
    main_addr = 16'h0400;
    wait_req("dl2", 22'h0200, lat);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; downloading = 1'b1;
    data_dst = 1'b1; data_read = 16'h7766;
    @(negedge clk);
    data_rdy = 1'b1; data_read = 16'h0000;
    @(negedge clk);
    data_dst = 1'b0; data_rdy = 1'b0;
    check("dl2_req", 32'(sdram_req), 32'd0);
    downloading = 1'b0;
    #1 check("dl2_ok", 32'(main_ok), 32'd0);
    wait_req("dl3", 22'h0200, lat);
    check("dl3_lat", 32'(lat), 32'd1);
    burst(16'h9988, 16'h0000);
    check("dl3_ok", 32'(main_ok), 32'd1);
    check("dl3_dout", 32'(main_dout), 32'h88);
    main_cs = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtroadf_sdram_arb.md
# jtroadf_sdram_arb

Shares the single SDRAM read port among the five Road Fighter ROM consumers: scroll tiles, object tiles, PCM samples, sound CPU and main CPU. Each requester gets a one-entry hit cache and an `ok` flag. Requests are granted by fixed priority and issued as two-word SDRAM bursts. The block sits between the game-level video, sound and CPU address buses and the framework SDRAM controller, and blocks all traffic while ROMs are downloading.

## Interface
Parameters:
- `SCR_OFFSET`, 22'h0, SDRAM word offset of scroll ROM (slot 0, 32-bit).
- `OBJ_OFFSET`, 22'h0, SDRAM word offset of object ROM (slot 1, 32-bit).
- `PCM_OFFSET`, 22'h0, SDRAM word offset of PCM ROM (slot 2, 8-bit).
- `SND_OFFSET`, 22'h0, SDRAM word offset of sound CPU ROM (slot 3, 8-bit).
- `MAIN_OFFSET`, 22'h0, SDRAM word offset of main CPU ROM (slot 4, 8-bit).

Ports:
- `clk` in 1: single clock (48 MHz); everything is synchronous to it.
- `rst` in 1: reset, synchronous, active-low.
- `downloading` in 1: ROM download in progress.
- `scr_cs`, `obj_cs`, `pcm_cs`, `snd_cs`, `main_cs` in 1 each: slot request.
- `scr_addr` in 15, `obj_addr` in 15: byte addresses, bit 0 always 0.
- `pcm_addr` in 16, `snd_addr` in 13, `main_addr` in 16: byte addresses.
- `scr_dout`, `obj_dout` out 32: cached data for slots 0 and 1.
- `pcm_dout`, `snd_dout`, `main_dout` out 8: cached data for slots 2–4.
- `scr_ok`, `obj_ok`, `pcm_ok`, `snd_ok`, `main_ok` out 1 each: data valid for the current address.
- `sdram_req` out 1: read request to the SDRAM controller.
- `sdram_addr` out 22: SDRAM word address.
- `sdram_ack` in 1: request accepted (one-cycle pulse).
- `data_dst` in 1: `data_read` holds a valid word this cycle.
- `data_rdy` in 1: last word of the burst; coincides with the second `data_dst`.
- `data_read` in 16: SDRAM read data.

## Operation
- Word address: `OFFSET + (addr >> 1)`, zero-extended to 22 bits. 32-bit slots additionally force bit 0 of the word address to 0.
- Per-slot cache contents: `valid`, `tag` (full slot byte address latched at grant), `data` (32 bits for slots 0–1, 16 bits for slots 2–4).
- Hit: `ok = cs & valid & (addr == tag)`.
  - Combinational from registered cache state.
  - 8-bit `dout` selects `data[15:8]` when `addr[0]` is 1, else `data[7:0]`.
  - The hit compare for 8-bit slots ignores `addr[0]`.
- Pending: `cs & ~ok` and slot not currently in flight.
- Priority, highest first: MAIN, SND, OBJ, PCM, SCR. No round-robin.
- FSM states:
  - `IDLE`: if `downloading`, stay. Otherwise, if any slot is pending, grant the highest-priority one: latch slot index and tag, drive `sdram_addr`, go to `REQ`.
  - `REQ`: `sdram_req` = 1 and `sdram_addr` held stable. On `sdram_ack`, go to `WAIT`.
  - `WAIT`: first `data_dst` stores the word into `data[15:0]`. Second `data_dst` (with `data_rdy`) stores into `data[31:16]` (32-bit slots) or is discarded (8-bit slots). On `data_rdy`, set `valid` and `tag`, go to `IDLE`.
- The burst always completes, even if the slot's `cs` drops or its address changes mid-transaction. Cache is filled with the granted address; `ok` then reflects the mismatch and a new request is issued afterwards.
- `downloading` high:
  - All `valid` bits are cleared every cycle.
  - No new grants; any in-flight burst is finished but its fill is discarded.
  - All `ok` outputs are 0.
- `data_dst` or `data_rdy` outside `WAIT` is ignored.

## Timing
- Reset values:
  - FSM in `IDLE`; `sdram_req` 0; `sdram_addr` 0.
  - All `valid` 0, so every `ok` is 0; all `dout` 0.
- Reset mid-burst returns to `IDLE` immediately. Remaining `data_dst`/`data_rdy` from the aborted burst are ignored.
- Grant latency: a pending slot seen in `IDLE` at cycle n has `sdram_req` high at cycle n+1.
- Back-to-back: after the `data_rdy` cycle, one `IDLE` cycle, then the next `REQ`.
- `ok` rises the cycle after `data_rdy` and falls in the same cycle `addr` changes or `cs` drops.
- The controller may take `sdram_ack` on the first `REQ` cycle.

## Structure
- Shared package `jtroadf_arb_pkg`: slot index constants (`SLOT_SCR`=0 … `SLOT_MAIN`=4), FSM state enum, priority order list.
- Sub-module `jtroadf_arb_slot`, parameterised by address width, data width and offset. It holds the cache, hit compare, byte select and word-address computation. Instantiated five times.
- The top level holds the priority encoder, FSM and SDRAM mux.

## Test plan
- Single request: `main_cs`=1, `main_addr`=16'h0123, `MAIN_OFFSET`=0. Expect `sdram_addr`=22'h0091 one cycle later. Controller returns words 16'hBEEF then 16'h0000; expect `main_dout`=8'hBE and `main_ok`=1 one cycle after `data_rdy`.
- 32-bit assembly: `scr_addr`=15'h0004, `SCR_OFFSET`=22'h8000. Expect `sdram_addr`=22'h8002. Words 16'h3344 then 16'h1122; expect `scr_dout`=32'h11223344.
- Priority: `scr_cs`, `obj_cs`, `snd_cs` and `main_cs` all rise in the same cycle. Expect grants in order MAIN, SND, OBJ, SCR, each separated by a full burst.
- Hit and mismatch: after a fill at `pcm_addr`=16'h0010, changing to 16'h0011 keeps `pcm_ok`=1 with the high byte output. Changing to 16'h0012 drops `pcm_ok` the same cycle and a new request is issued.
- Address change in flight: `snd_addr` changes during `WAIT`. After `data_rdy`, `snd_ok`=0, then a second request is issued for the new address.
- Reset and download: `rst`=0 during `WAIT` leaves the FSM in `IDLE` with `sdram_req`=0. Stray `data_rdy` afterwards changes nothing. `downloading`=1 clears every `ok` and holds `sdram_req`=0 while all `cs` are high.
